// File: rtl/tt_memop_sync_resp_if.sv
// ----------------------------------------------------------------------------
// tt_memop_sync_resp_if
// Bundle of the memop synchronisation handshake between the vector unit /
// memory core (master) and the response tracker (slave).
//
// Signals (named from the tracker's point of view):
//   i_memop_sync_start  memop-start pulse from the vector unit
//   i_is_load           memop type at start (1 = load, 0 = store)
//   i_req_valid         one memory request issued for the current memop
//   i_req_last          qualifies i_req_valid: final request of the memop
//   i_resp_valid        one load-data return or store ack
//   i_kill              flush the current memop
//   o_req_ready         request accepted this cycle if i_req_valid
//   o_memop_sync_end    single-cycle completion pulse
//   o_busy              tracker not idle
//   o_is_load           memop type latched at start
//   o_outstanding       current outstanding request count
//   o_err               sticky protocol-error flag
// ----------------------------------------------------------------------------
interface tt_memop_sync_resp_if #(
  parameter int CNT_W = 5
);
  logic             i_memop_sync_start;
  logic             i_is_load;
  logic             i_req_valid;
  logic             i_req_last;
  logic             i_resp_valid;
  logic             i_kill;
  logic             o_req_ready;
  logic             o_memop_sync_end;
  logic             o_busy;
  logic             o_is_load;
  logic [CNT_W-1:0] o_outstanding;
  logic             o_err;

  modport master (
    output i_memop_sync_start, i_is_load, i_req_valid, i_req_last,
           i_resp_valid, i_kill,
    input  o_req_ready, o_memop_sync_end, o_busy, o_is_load,
           o_outstanding, o_err
  );

  modport slave (
    input  i_memop_sync_start, i_is_load, i_req_valid, i_req_last,
           i_resp_valid, i_kill,
    output o_req_ready, o_memop_sync_end, o_busy, o_is_load,
           o_outstanding, o_err
  );
endinterface

// File: rtl/tt_memop_sync_resp.sv
// ----------------------------------------------------------------------------
// tt_memop_sync_resp
// Tracks one vector memop from start to completion: counts memory requests
// that are still waiting for a response, throttles issue at MAX_OUTST, and
// pulses o_memop_sync_end once the last request has been issued and every
// response has returned. Illegal handshake events are ignored and recorded
// in a sticky error flag that only reset clears.
//
// Ports:
//   i_clk    clock, all state updates on the rising edge
//   i_reset  synchronous active-high reset
//   bus      tt_memop_sync_resp_if.slave (handshake inputs, status outputs)
//
// Parameters:
//   MAX_OUTST  maximum outstanding requests per memop
//   CNT_W      counter width, 2**CNT_W must exceed MAX_OUTST
//
// Every output is a flop. The flop inputs are computed from the next state
// and next count, so each output equals the combinational definition
// evaluated on the current registered state.
// ----------------------------------------------------------------------------
module tt_memop_sync_resp #(
  parameter int MAX_OUTST = 16,
  parameter int CNT_W     = 5
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  tt_memop_sync_resp_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_END   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_OUTST);
  localparam logic [CNT_W-1:0] ZERO_C = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t           state_r;
  state_t           state_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;
  logic             ready_r;
  logic             ready_nxt_s;
  logic             busy_r;
  logic             busy_nxt_s;
  logic             end_r;
  logic             end_nxt_s;
  logic             is_load_r;
  logic             is_load_nxt_s;
  logic             err_r;
  logic             err_nxt_s;

  logic             in_idle_s;
  logic             in_issue_s;
  logic             in_drain_s;
  logic             in_end_s;
  logic             req_acc_s;
  logic             resp_ok_s;
  logic             dec_s;
  logic             err_evt_s;

  assign in_idle_s  = (state_r == ST_IDLE);
  assign in_issue_s = (state_r == ST_ISSUE);
  assign in_drain_s = (state_r == ST_DRAIN);
  assign in_end_s   = (state_r == ST_END);

  // ready_r is only ever set while in ISSUE below the limit
  assign req_acc_s = bus.i_req_valid && ready_r;
  assign resp_ok_s = bus.i_resp_valid && (in_issue_s || in_drain_s);
  // A response with nothing outstanding only counts when it pairs with a
  // request accepted in the same cycle; otherwise the counter would wrap.
  assign dec_s     = resp_ok_s && ((cnt_r != ZERO_C) || req_acc_s);

  assign err_evt_s =
      (bus.i_resp_valid && !(in_issue_s || in_drain_s))
    || (resp_ok_s && (cnt_r == ZERO_C) && !req_acc_s)
    || (bus.i_req_valid && !in_issue_s)
    || (bus.i_memop_sync_start && !in_idle_s);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; kill wins over every other event
  always_comb begin
    state_nxt_s = state_r;
    if (bus.i_kill) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.i_memop_sync_start) begin
            state_nxt_s = ST_ISSUE;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ISSUE: begin
          if (req_acc_s && bus.i_req_last) begin
            state_nxt_s = ST_DRAIN;
          end else begin
            state_nxt_s = ST_ISSUE;
          end
        end
        ST_DRAIN: begin
          // registered count: completion is seen one cycle after it drains
          if (cnt_r == ZERO_C) begin
            state_nxt_s = ST_END;
          end else begin
            state_nxt_s = ST_DRAIN;
          end
        end
        ST_END: begin
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Output/datapath next values derived from the next state
  always_comb begin
    cnt_nxt_s     = cnt_r;
    is_load_nxt_s = is_load_r;
    if (bus.i_kill) begin
      cnt_nxt_s = ZERO_C;
    end else if (req_acc_s && !dec_s) begin
      cnt_nxt_s = cnt_r + ONE_C;
    end else if (!req_acc_s && dec_s) begin
      cnt_nxt_s = cnt_r - ONE_C;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    if (bus.i_kill) begin
      is_load_nxt_s = 1'b0;
    end else if (in_idle_s && bus.i_memop_sync_start) begin
      is_load_nxt_s = bus.i_is_load;
    end else if (in_end_s) begin
      is_load_nxt_s = 1'b0;
    end else begin
      is_load_nxt_s = is_load_r;
    end

    // illegal events that a kill flushes are not recorded
    err_nxt_s   = err_r | (err_evt_s & !bus.i_kill);
    ready_nxt_s = (state_nxt_s == ST_ISSUE) && (cnt_nxt_s < MAX_C);
    busy_nxt_s  = (state_nxt_s != ST_IDLE);
    end_nxt_s   = (state_nxt_s == ST_END);
  end

  // Counter, flags and output flops
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      cnt_r     <= ZERO_C;
      is_load_r <= 1'b0;
      err_r     <= 1'b0;
      ready_r   <= 1'b0;
      busy_r    <= 1'b0;
      end_r     <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      is_load_r <= is_load_nxt_s;
      err_r     <= err_nxt_s;
      ready_r   <= ready_nxt_s;
      busy_r    <= busy_nxt_s;
      end_r     <= end_nxt_s;
    end
  end

  assign bus.o_req_ready      = ready_r;
  assign bus.o_memop_sync_end = end_r;
  assign bus.o_busy           = busy_r;
  assign bus.o_is_load        = is_load_r;
  assign bus.o_outstanding    = cnt_r;
  assign bus.o_err            = err_r;

endmodule

// File: tb/tb_tt_memop_sync_resp.sv
// Directed bench for tt_memop_sync_resp. Each stimulus step pushes the
// hand-computed post-edge outputs into a queue; a monitor pops and compares
// one entry just after every rising edge.
module tb_tt_memop_sync_resp;

  localparam int MAX_OUTST = 16;
  localparam int CNT_W     = 5;

  logic clk = 1'b0;
  logic rst = 1'b1;

  tt_memop_sync_resp_if #(.CNT_W(CNT_W)) bus ();

  tt_memop_sync_resp #(.MAX_OUTST(MAX_OUTST), .CNT_W(CNT_W)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    bit    busy;
    bit    rdy;
    bit    send;
    bit    ld;
    int    cnt;
    bit    err;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   bad    = 0;
  int   n_end  = 0;

  // monitor: compare registered outputs just after each edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (bus.o_memop_sync_end === 1'b1) n_end++;
    if (q.size() > 0) begin
      e = q.pop_front();
      total++;
      if (bus.o_busy !== e.busy || bus.o_req_ready !== e.rdy ||
          bus.o_memop_sync_end !== e.send || bus.o_is_load !== e.ld ||
          int'(bus.o_outstanding) != e.cnt || bus.o_err !== e.err) begin
        bad++;
        $display("FAIL %s: got busy=%b rdy=%b end=%b ld=%b cnt=%0d err=%b want busy=%b rdy=%b end=%b ld=%b cnt=%0d err=%b",
                 e.nm, bus.o_busy, bus.o_req_ready, bus.o_memop_sync_end,
                 bus.o_is_load, bus.o_outstanding, bus.o_err,
                 e.busy, e.rdy, e.send, e.ld, e.cnt, e.err);
      end
    end
  end

  // drive one cycle of inputs and queue the outputs expected after the edge
  task automatic step(input string nm, input bit rs, input bit kl, input bit st,
                      input bit ld, input bit rv, input bit rl, input bit rsp,
                      input bit eb, input bit er, input bit ee, input bit el,
                      input int ec, input bit eerr);
    exp_t e;
    rst                    = rs;
    bus.i_kill             = kl;
    bus.i_memop_sync_start = st;
    bus.i_is_load          = ld;
    bus.i_req_valid        = rv;
    bus.i_req_last         = rl;
    bus.i_resp_valid       = rsp;
    e.nm = nm; e.busy = eb; e.rdy = er; e.send = ee; e.ld = el; e.cnt = ec; e.err = eerr;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  initial begin
    bus.i_memop_sync_start = 1'b0;
    bus.i_is_load          = 1'b0;
    bus.i_req_valid        = 1'b0;
    bus.i_req_last         = 1'b0;
    bus.i_resp_valid       = 1'b0;
    bus.i_kill             = 1'b0;
    #2;
    //    name         rs kl st ld rv rl rsp  busy rdy end ld cnt err
    step("reset0",      1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);
    step("reset1",      1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);

    // load memop: 3 requests then 3 responses
    step("ld_start",    0, 0, 1, 1, 0, 0, 0,   1,  1,  0,  1, 0,  0);
    step("ld_req1",     0, 0, 0, 0, 1, 0, 0,   1,  1,  0,  1, 1,  0);
    step("ld_req2",     0, 0, 0, 0, 1, 0, 0,   1,  1,  0,  1, 2,  0);
    step("ld_req3last", 0, 0, 0, 0, 1, 1, 0,   1,  0,  0,  1, 3,  0);
    step("ld_resp1",    0, 0, 0, 0, 0, 0, 1,   1,  0,  0,  1, 2,  0);
    step("ld_resp2",    0, 0, 0, 0, 0, 0, 1,   1,  0,  0,  1, 1,  0);
    step("ld_resp3",    0, 0, 0, 0, 0, 0, 1,   1,  0,  0,  1, 0,  0);
    step("ld_end",      0, 0, 0, 0, 0, 0, 0,   1,  0,  1,  1, 0,  0);
    step("ld_idle",     0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);

    // backpressure at 16 outstanding (store memop)
    step("bp_start",    0, 0, 1, 0, 0, 0, 0,   1,  1,  0,  0, 0,  0);
    for (int i = 1; i <= 16; i++)
      step("bp_fill",   0, 0, 0, 0, 1, 0, 0,   1, (i < 16), 0, 0, i, 0);
    step("bp_held",     0, 0, 0, 0, 1, 0, 0,   1,  0,  0,  0, 16, 0);
    step("bp_held_rsp", 0, 0, 0, 0, 1, 0, 1,   1,  1,  0,  0, 15, 0);
    step("bp_17th",     0, 0, 0, 0, 1, 0, 0,   1,  0,  0,  0, 16, 0);
    for (int i = 15; i >= 5; i--)
      step("bp_drain",  0, 0, 0, 0, 0, 0, 1,   1,  1,  0,  0, i,  0);
    step("sim_reqrsp5", 0, 0, 0, 0, 1, 0, 1,   1,  1,  0,  0, 5,  0);
    for (int i = 4; i >= 0; i--)
      step("drain_to0", 0, 0, 0, 0, 0, 0, 1,   1,  1,  0,  0, i,  0);
    // last request paired with a same-cycle response at count 0
    step("last_at0",    0, 0, 0, 0, 1, 1, 1,   1,  0,  0,  0, 0,  0);
    step("last_end",    0, 0, 0, 0, 0, 0, 0,   1,  0,  1,  0, 0,  0);
    step("last_idle",   0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);

    // kill in DRAIN with 4 outstanding, then kill+start
    step("k_start",     0, 0, 1, 1, 0, 0, 0,   1,  1,  0,  1, 0,  0);
    step("k_req1",      0, 0, 0, 0, 1, 0, 0,   1,  1,  0,  1, 1,  0);
    step("k_req2",      0, 0, 0, 0, 1, 0, 0,   1,  1,  0,  1, 2,  0);
    step("k_req3",      0, 0, 0, 0, 1, 0, 0,   1,  1,  0,  1, 3,  0);
    step("k_req4last",  0, 0, 0, 0, 1, 1, 0,   1,  0,  0,  1, 4,  0);
    step("k_kill",      0, 1, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);
    step("k_nopulse",   0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);
    step("k_killstart", 0, 1, 1, 1, 0, 0, 0,   0,  0,  0,  0, 0,  0);
    step("k_stayidle",  0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);

    // protocol errors
    step("e_rsp_idle",  0, 0, 0, 0, 0, 0, 1,   0,  0,  0,  0, 0,  1);
    step("e_sticky",    0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  1);
    step("e_rst1",      1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);
    step("e_start",     0, 0, 1, 1, 0, 0, 0,   1,  1,  0,  1, 0,  0);
    step("e_st_issue",  0, 0, 1, 0, 0, 0, 0,   1,  1,  0,  1, 0,  1);
    step("e_lastreq",   0, 0, 0, 0, 1, 1, 0,   1,  0,  0,  1, 1,  1);
    step("e_rst2",      1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);
    step("e_start2",    0, 0, 1, 0, 0, 0, 0,   1,  1,  0,  0, 0,  0);
    step("e_last2",     0, 0, 0, 0, 1, 1, 0,   1,  0,  0,  0, 1,  0);
    step("e_req_drain", 0, 0, 0, 0, 1, 0, 0,   1,  0,  0,  0, 1,  1);
    step("e_resp",      0, 0, 0, 0, 0, 0, 1,   1,  0,  0,  0, 0,  1);
    step("e_end",       0, 0, 0, 0, 0, 0, 0,   1,  0,  1,  0, 0,  1);
    step("e_idle",      0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  1);
    step("e_kill_keep", 0, 1, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  1);

    // reset mid-operation in ISSUE with 7 outstanding
    step("r_rst",       1, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);
    step("r_start",     0, 0, 1, 1, 0, 0, 0,   1,  1,  0,  1, 0,  0);
    step("r_rsp_at0",   0, 0, 0, 0, 0, 0, 1,   1,  1,  0,  1, 0,  1);
    for (int i = 1; i <= 7; i++)
      step("r_fill",    0, 0, 0, 0, 1, 0, 0,   1,  1,  0,  1, i,  1);
    step("r_reset",     1, 1, 0, 0, 1, 0, 1,   0,  0,  0,  0, 0,  0);
    step("r_after",     0, 0, 0, 0, 0, 0, 0,   0,  0,  0,  0, 0,  0);

    // let the monitor consume everything, bounded
    for (int i = 0; i < 10 && q.size() > 0; i++) @(posedge clk);
    #3;
    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL drain_queue: got %0d entries left want 0", q.size());
    end
    total++;
    if (n_end != 3) begin
      bad++;
      $display("FAIL end_pulses: got %0d want 3", n_end);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
